lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lib_pkg.sv | 56 +++++
 rtl/lsu_align.sv | 75 +++++++
 rtl/lsu_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lib_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RV32I load/store funct3 encodings, access-size codes, the
// controller state enum and small decode helpers used by lsu_ctrl and
// lsu_align.
package lib_pkg;

    // Only a 32-bit datapath is supported.
    localparam int unsigned LSU_WIDTH = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // True when funct3 names a real RV32I load/store.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        if (is_load) begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end else begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return ok;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   i_funct3  - load/store funct3 (size in [1:0], unsigned flag in [2])
//   i_offset  - byte address bits [1:0]
//   i_wdata   - right-justified store data
//   i_rdata   - full memory word read data
//   o_be      - byte-lane enables for the access size and offset
//   o_wdata   - store data replicated across all lanes
//   o_rdata   - load data shifted down and sign/zero extended
// Low offset bits that do not fit the access size are treated as zero,
// so a misaligned halfword/word falls back to the naturally aligned one.
module lsu_align
    import lib_pkg::*;
#(
    parameter int unsigned WIDTH = LSU_WIDTH
) (
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_offset,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH-1:0]   i_rdata,
    output logic [WIDTH/8-1:0] o_be,
    output logic [WIDTH-1:0]   o_wdata,
    output logic [WIDTH-1:0]   o_rdata
);

    localparam int unsigned BE_W = WIDTH / 8;

    logic [1:0]       w_off_eff;
    logic [WIDTH-1:0] w_shift;

    // Effective lane offset after dropping size-misaligned bits
    always_comb begin
        w_off_eff = 2'b00;
        case (i_funct3[1:0])
            SZ_BYTE: w_off_eff = i_offset;
            SZ_HALF: w_off_eff = {i_offset[1], 1'b0};
            default: w_off_eff = 2'b00;
        endcase
    end

    // Lane enables and replicated store data
    always_comb begin
        o_be    = '1;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            SZ_BYTE: begin
                o_be    = BE_W'(1) << w_off_eff;
                o_wdata = {(BE_W){i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = BE_W'(3) << w_off_eff;
                o_wdata = {(BE_W/2){i_wdata[15:0]}};
            end
            default: begin
                o_be    = '1;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Right-justify the addressed lanes, then extend
    always_comb begin
        w_shift = i_rdata >> {w_off_eff, 3'b000};
        o_rdata = '0;
        case (i_funct3)
            F3_LB:   o_rdata = {{(WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            F3_LH:   o_rdata = {{(WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            F3_LW:   o_rdata = w_shift;
            F3_LBU:  o_rdata = {{(WIDTH-8){1'b0}}, w_shift[7:0]};
            F3_LHU:  o_rdata = {{(WIDTH-16){1'b0}}, w_shift[15:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one core request at a time, issues a
// single word-aligned memory access and returns a one-cycle response.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - request handshake (ready only in IDLE)
//   req_load/funct3/addr/wdata  - request payload
//   resp_valid/rdata/fault      - one-cycle completion pulse and result
//   mem_req/we/addr/be/wdata    - memory command, held until mem_ack
//   mem_ack/mem_rdata           - memory completion and read word
// Build option: LSU_MISALIGN_TRAP_EN - misaligned halfword/word accesses
// fault without touching memory; when undefined they are forced aligned.
module lsu_ctrl
    import lib_pkg::*;
#(
    parameter int unsigned WIDTH = LSU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_load,
    input  logic [2:0]         req_funct3,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_fault,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH/8-1:0] mem_be,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam int unsigned BE_W = WIDTH / 8;

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;

    // Captured request attributes needed for load extension
    logic       r_load;
    logic [2:0] r_funct3;
    logic [1:0] r_offset;

    // Registered outputs
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_rdata;
    logic             r_resp_fault;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [BE_W-1:0]  r_mem_be;
    logic [WIDTH-1:0] r_mem_wdata;

    logic             w_accept;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_fault;
    logic             w_req_ready_nxt;
    logic             w_mem_req_nxt;
    logic             w_resp_valid_nxt;
    logic [2:0]       w_al_funct3;
    logic [1:0]       w_al_offset;
    logic [BE_W-1:0]  w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_illegal = !f3_legal(req_load, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_illegal | w_misalign;

    // One aligner serves both phases: request fields while IDLE (to build
    // the memory command), captured fields afterwards (to extend the load).
    assign w_al_funct3 = (r_state == ST_IDLE) ? req_funct3    : r_funct3;
    assign w_al_offset = (r_state == ST_IDLE) ? req_addr[1:0] : r_offset;

    lsu_align #(
        .WIDTH(WIDTH)
    ) u_align (
        .i_funct3 (w_al_funct3),
        .i_offset (w_al_offset),
        .i_wdata  (req_wdata),
        .i_rdata  (mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; mem_ack only matters in ACCESS
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_fault ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        w_req_ready_nxt  = 1'b0;
        w_mem_req_nxt    = 1'b0;
        w_resp_valid_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE:   w_req_ready_nxt  = 1'b1;
            ST_ACCESS: w_mem_req_nxt    = 1'b1;
            ST_DONE:   w_resp_valid_nxt = 1'b1;
            default:   w_req_ready_nxt  = 1'b1;
        endcase
    end

    // Handshake/status output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            // A fault goes straight to DONE, so it is only high with resp_valid
            r_resp_fault <= w_accept & w_fault;
        end
    end

    // Request capture, memory command and load data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load       <= 1'b0;
            r_funct3     <= 3'b000;
            r_offset     <= 2'b00;
            r_resp_rdata <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (w_accept) begin
                r_load       <= req_load;
                r_funct3     <= req_funct3;
                r_offset     <= req_addr[1:0];
                r_resp_rdata <= '0;
                if (w_fault) begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_be    <= '0;
                    r_mem_wdata <= '0;
                end else begin
                    r_mem_we    <= ~req_load;
                    r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= req_load ? '0 : w_wdata;
                end
            end
            if ((r_state == ST_ACCESS) && mem_ack) begin
                r_resp_rdata <= r_load ? w_rdata : '0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule
